// File: rtl/rv32i_types.sv
// Shared types for the fetch front end.
//   fetch_state_t : fetch FSM states (IDLE / REQ / DISCARD)
//   fq_entry_t    : one fetch-queue entry, instruction word plus its PC
//   PC_STEP       : sequential fetch increment in bytes
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fq_entry_t;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: DEPTH-entry circular queue of fq_entry_t.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush_i       empties the queue next cycle; wins over push/pop
//   push_i        write din_i at tail (dropped if full and not popping)
//   pop_i         advance head (ignored when empty)
//   din_i         entry to write
//   head_o        entry at head; all zeros while empty
//   count_o       number of valid entries, 0..DEPTH
//   full_o        count == DEPTH
//   empty_o       count == 0
module fetch_fifo
  import rv32i_types::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  fq_entry_t     din_i,
  output fq_entry_t     head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);
  assign count_o = count_q;

  // A push into a full queue is accepted only when a pop frees a slot
  // in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointers are PW bits wide and DEPTH is a power of two, so the
  // increments wrap modulo DEPTH on their own.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) tail_d = tail_q + PW'(1);
      if (do_pop)  head_d = head_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[tail_q] <= din_i;
  end

  assign head_o = empty_o ? '0 : mem_q[head_q];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: front-end fetch stage feeding the instruction register.
// Owns the fetch PC, issues one instruction-cache read at a time and
// buffers returned words with their PCs in a DEPTH-entry queue.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_read                read request (held until instr_mem_resp)
//   instr_mem_address         word-aligned fetch address
//   instr_mem_resp            one-cycle pulse: rdata valid, request done
//   instr_mem_rdata           returned instruction word
//   redirect, redirect_pc     ROB branch: flush queue, refetch at target
//   deq                       consumer takes the head entry this cycle
//   fq_valid/fq_instr/fq_pc   head entry (registered state only)
//   fq_full                   queue holds DEPTH entries
//   dbg_state_o, dbg_count_o  FSM state and queue occupancy
//
// Handshakes: a read is in flight while instr_read=1; address and
// instr_read stay constant until the cycle instr_mem_resp=1, which
// completes it. The head entry transfers on a cycle with fq_valid=1 and
// deq=1; deq with fq_valid=0 does nothing.
module fetch_unit
  import rv32i_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h6000_0000,
  parameter int          DEPTH    = 4,
  localparam int         CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          instr_read,
  output logic [31:0]   instr_mem_address,
  input  logic          instr_mem_resp,
  input  logic [31:0]   instr_mem_rdata,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          deq,
  output logic          fq_valid,
  output logic [31:0]   fq_instr,
  output logic [31:0]   fq_pc,
  output logic          fq_full,
  output fetch_state_t  dbg_state_o,
  output logic [CW-1:0] dbg_count_o
);

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_M1_C  = CW'(DEPTH - 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   target_q, target_d;   // redirect target held during DISCARD

  logic [31:0]   redir_pc_al;
  logic          deq_fire;
  logic          fifo_push;
  logic [CW-1:0] fq_count;
  logic [CW-1:0] count_after_pop;
  logic          fq_empty;
  logic          fifo_full;
  fq_entry_t     fifo_din;
  fq_entry_t     fifo_head;

  assign redir_pc_al     = redirect_pc & ~32'h3;
  assign deq_fire        = deq & ~fq_empty;
  assign count_after_pop = fq_count - CW'(deq_fire);

  // Only a REQ response with no competing redirect lands in the queue;
  // DISCARD responses and responses while IDLE are dropped.
  assign fifo_push       = (state_q == REQ) & instr_mem_resp & ~redirect;
  assign fifo_din        = '{instr: instr_mem_rdata, pc: fetch_pc_q};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect),
    .push_i  (fifo_push),
    .pop_i   (deq_fire),
    .din_i   (fifo_din),
    .head_o  (fifo_head),
    .count_o (fq_count),
    .full_o  (fifo_full),
    .empty_o (fq_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      target_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = redir_pc_al;
          state_d    = REQ;
        end else if (count_after_pop < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect) begin
          if (instr_mem_resp) begin
            // Request already done: drop its word, start the target now.
            fetch_pc_d = redir_pc_al;
            state_d    = REQ;
          end else begin
            // Request still in flight: finish it, then go to the target.
            target_d = redir_pc_al;
            state_d  = DISCARD;
          end
        end else if (instr_mem_resp) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
          // After this push the queue holds count_after_pop+1 entries.
          state_d    = (count_after_pop < DEPTH_M1_C) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (instr_mem_resp) begin
          fetch_pc_d = redirect ? redir_pc_al : target_q;
          state_d    = REQ;
        end else if (redirect) begin
          target_d = redir_pc_al;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    instr_read        = (state_q != IDLE);
    instr_mem_address = fetch_pc_q;
    fq_valid          = ~fq_empty;
    fq_instr          = fifo_head.instr;
    fq_pc             = fifo_head.pc;
    fq_full           = fifo_full;
    dbg_state_o       = state_q;
    dbg_count_o       = fq_count;
  end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import rv32i_types::*;

  localparam logic [31:0] RESET_PC = 32'h6000_0000;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_read;
  logic [31:0]  instr_mem_address;
  logic         instr_mem_resp;
  logic [31:0]  instr_mem_rdata;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic         deq;
  logic         fq_valid;
  logic [31:0]  fq_instr;
  logic [31:0]  fq_pc;
  logic         fq_full;
  fetch_state_t dbg_state;
  logic [2:0]   dbg_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .instr_read        (instr_read),
    .instr_mem_address (instr_mem_address),
    .instr_mem_resp    (instr_mem_resp),
    .instr_mem_rdata   (instr_mem_rdata),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .deq               (deq),
    .fq_valid          (fq_valid),
    .fq_instr          (fq_instr),
    .fq_pc             (fq_pc),
    .fq_full           (fq_full),
    .dbg_state_o       (dbg_state),
    .dbg_count_o       (dbg_count)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] pc);
    return pc ^ 32'h13A5_0000;
  endfunction

  // ---------------- drivers ----------------
  // Inputs change and outputs are sampled 1 time unit after posedge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for a request, check its address, answer lat cycles later.
  task automatic serve(input int lat, input logic [31:0] exp_addr, input string tag);
    int n = 0;
    while (!instr_read && n < 20) begin
      tick();
      n++;
    end
    if (!instr_read) check_eq({tag, "_timeout"}, 32'(instr_read), 32'd1);
    check_eq({tag, "_addr"}, instr_mem_address, exp_addr);
    repeat (lat) tick();
    instr_mem_resp  = 1'b1;
    instr_mem_rdata = word_of(exp_addr);
    tick();
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = '0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst             = 1'b1;
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = '0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    deq             = 1'b0;
    tick();
    tick();

    // Reset state
    check_eq("rst_read",  32'(instr_read), 32'd0);
    check_eq("rst_addr",  instr_mem_address, RESET_PC);
    check_eq("rst_valid", 32'(fq_valid), 32'd0);
    check_eq("rst_instr", fq_instr, 32'd0);
    check_eq("rst_pc",    fq_pc, 32'd0);
    check_eq("rst_full",  32'(fq_full), 32'd0);
    rst = 1'b0;

    // Fill the queue with four sequential fetches
    for (int i = 0; i < 4; i++)
      serve(1, RESET_PC + 32'(4 * i), $sformatf("fill%0d", i));
    check_eq("fill_full",  32'(fq_full), 32'd1);
    check_eq("fill_read",  32'(instr_read), 32'd0);
    check_eq("fill_hpc",   fq_pc, 32'h6000_0000);
    check_eq("fill_hins",  fq_instr, word_of(32'h6000_0000));
    check_eq("fill_count", 32'(dbg_count), 32'd4);

    // One deq from a full queue restarts fetching at 0x60000010
    deq = 1'b1;
    tick();
    deq = 1'b0;
    check_eq("deq_read",  32'(instr_read), 32'd1);
    check_eq("deq_addr",  instr_mem_address, 32'h6000_0010);
    check_eq("deq_hpc",   fq_pc, 32'h6000_0004);
    check_eq("deq_hins",  fq_instr, word_of(32'h6000_0004));
    check_eq("deq_count", 32'(dbg_count), 32'd3);

    // Redirect mid-request (unaligned target), response 3 cycles later
    redirect    = 1'b1;
    redirect_pc = 32'h6000_0101;
    tick();
    redirect    = 1'b0;
    redirect_pc = '0;
    check_eq("rd_valid", 32'(fq_valid), 32'd0);
    check_eq("rd_state", 32'(dbg_state), 32'(DISCARD));
    check_eq("rd_hold",  instr_mem_address, 32'h6000_0010);
    check_eq("rd_read",  32'(instr_read), 32'd1);
    tick();
    tick();
    check_eq("rd_hold2", instr_mem_address, 32'h6000_0010);
    instr_mem_resp  = 1'b1;
    instr_mem_rdata = 32'hBAD0_0001;
    tick();
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = '0;
    check_eq("rd_valid2", 32'(fq_valid), 32'd0);
    check_eq("rd_read2",  32'(instr_read), 32'd1);
    check_eq("rd_naddr",  instr_mem_address, 32'h6000_0100);

    // Redirect and response in the same cycle
    tick();
    instr_mem_resp  = 1'b1;
    instr_mem_rdata = 32'hBAD0_0002;
    redirect        = 1'b1;
    redirect_pc     = 32'h6000_0200;
    tick();
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = '0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    check_eq("rr_valid", 32'(fq_valid), 32'd0);
    check_eq("rr_count", 32'(dbg_count), 32'd0);
    check_eq("rr_state", 32'(dbg_state), 32'(REQ));
    check_eq("rr_addr",  instr_mem_address, 32'h6000_0200);

    // Steady push+pop at count 2; pointers wrap twice
    serve(1, 32'h6000_0200, "pp_a");
    exp_q.push_back(32'h6000_0200);
    serve(1, 32'h6000_0204, "pp_b");
    exp_q.push_back(32'h6000_0204);
    check_eq("pp_count0", 32'(dbg_count), 32'd2);
    for (int k = 0; k < 8; k++) begin
      logic [31:0] a;
      a = 32'h6000_0208 + 32'(4 * k);
      check_eq($sformatf("pp_addr%0d", k), instr_mem_address, a);
      deq             = 1'b1;
      instr_mem_resp  = 1'b1;
      instr_mem_rdata = word_of(a);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(a);
      check_eq($sformatf("pp_hpc%0d", k),  fq_pc, exp_q[0]);
      check_eq($sformatf("pp_hins%0d", k), fq_instr, word_of(exp_q[0]));
      check_eq($sformatf("pp_cnt%0d", k),  32'(dbg_count), 32'd2);
    end
    deq             = 1'b0;
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = '0;

    // Reset while a request is in flight; late response ignored
    check_eq("rr2_read", 32'(instr_read), 32'd1);
    rst = 1'b1;
    tick();
    rst             = 1'b0;
    instr_mem_resp  = 1'b1;
    instr_mem_rdata = 32'hBAD0_0003;
    tick();
    instr_mem_resp  = 1'b0;
    instr_mem_rdata = '0;
    check_eq("late_addr",  instr_mem_address, RESET_PC);
    check_eq("late_valid", 32'(fq_valid), 32'd0);
    check_eq("late_count", 32'(dbg_count), 32'd0);

    // deq on an empty queue must not underflow
    deq = 1'b1;
    tick();
    deq = 1'b0;
    check_eq("edeq_count", 32'(dbg_count), 32'd0);
    check_eq("edeq_valid", 32'(fq_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
